coin_dispenser: RTL and testbench
=================================

# coin_dispenser

Change-return transmitter for the vending-machine coin interface. Accepts a refund request, holds a count, and drives a serial `coin` line with one-cycle pulses separated by idle gaps, so any coin-consuming block (e.g. the newspaper vendor) can count coins by sampling on `clk`. Tracks a finite coin hopper, stalls when it runs dry, and resumes on refill.

## Interface
- `AMT_W`, 4: width of refund request amount.
- `LVL_W`, 6: width of hopper level.
- `HOPPER_CAP`, 50: maximum hopper level (≤ 2^LVL_W−1).
- `INIT_LEVEL`, 20: hopper level after reset (≤ HOPPER_CAP).
- `GAP`, 1: low cycles after each coin pulse (≥1).

- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  refund request present.
- `req_amount`  in  AMT_W  coins to return.
- `req_ready`  out  1  block can accept a request.
- `refill`  in  1  add `refill_amount` to hopper this cycle.
- `refill_amount`  in  LVL_W  coins added on refill.
- `coin`  out  1  coin pulse, registered; one high cycle = one coin.
- `done`  out  1  one-cycle pulse: request fully paid.
- `busy`  out  1  request in progress.
- `starved`  out  1  stalled on empty hopper.
- `level`  out  LVL_W  current hopper level.

## Operation
- States: IDLE, PULSE, GAP, STALL, DONE.
- IDLE: `req_ready`=1. On `req_valid`: latch `remaining`=`req_amount`. Next state: DONE if amount=0; STALL if `level`=0; else PULSE.
- PULSE (1 cycle): `coin`=1, `level`−1, `remaining`−1. Next: GAP.
- GAP (GAP cycles, `coin`=0): at end, DONE if `remaining`=0; STALL if `level`=0; else PULSE.
- STALL: `starved`=1, `coin`=0. Leaves to PULSE the cycle after `level`>0.
- DONE (1 cycle): `done`=1. Next: IDLE.
- `busy`=1 in all states except IDLE.
- Hopper: next level = min(level − (PULSE?1:0) + (refill?refill_amount:0), HOPPER_CAP), computed at LVL_W+1 bits. Refill is accepted in every state. Level never underflows, because PULSE is entered only with level>0.
- `req_valid` is ignored outside IDLE. `req_amount` is sampled only on acceptance.

## Timing
- Reset values: `coin`=0, `done`=0, `busy`=0, `starved`=0, `req_ready`=1, `level`=INIT_LEVEL, state IDLE, `remaining`=0.
- Acceptance at edge k: first `coin` high in cycle k+1, with an unconstrained hopper.
- Pulse period is 1+GAP cycles. For amount N with no stall, `done` is high in cycle k+1+N·(1+GAP), and `req_ready` is high the cycle after that.
- Amount 0: `done` is high in cycle k+1, with no coin pulses.
- STALL exit: refill at edge r gives `level`>0 after r, and `coin` is high in cycle r+1.
- Refill in the same cycle as PULSE: the decrement and the addition both apply; the result saturates at the cap.
- `rstn` asserted mid-refund: everything returns to reset values immediately, including `level`=INIT_LEVEL. The partial refund is lost and `coin` drops asynchronously.

## Structure
- Package `coin_pkg`: state enum `disp_state_t` (IDLE, PULSE, GAP, STALL, DONE) and default width constants shared with the vendor block.
- Sub-module `coin_hopper`: level register, saturating add/decrement, `level` output, `empty` flag. The FSM plus the gap counter live in `coin_dispenser`.

## Test plan
- Reset with INIT_LEVEL=20, then request 3 with GAP=1 → `coin` high in cycles k+1, k+3, k+5; `done` in k+7; `level`=17.
- Request 0 → no pulses; `done` in cycle k+1; `level` unchanged.
- INIT_LEVEL=2, request 4 → two pulses, then `starved`=1. Refill 5 at edge r → pulses resume at r+1, `done` after 2 more pulses, `level`=3.
- `level`=49, CAP=50: refill 10 during PULSE → `level`=50, the saturated value.
- Assert `rstn` low mid-GAP of a request of 5 → `coin`=0, `busy`=0, `req_ready`=1, `level`=INIT_LEVEL. A new request afterwards starts cleanly.
- `req_valid` held high through a whole refund → exactly one request accepted per IDLE visit. Back-to-back requests of 2 and 1 → 3 pulses total, two `done` pulses.

Source files
------------

// File: rtl/coin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coin_pkg
// Description : Shared types and default widths for the coin interface
//               (coin dispenser and coin-consuming vendor blocks).
// Revision    : 1.0 - initial release
// ============================================================================
package coin_pkg;

  localparam int AMT_W_DEF      = 4;
  localparam int LVL_W_DEF      = 6;
  localparam int HOPPER_CAP_DEF = 50;
  localparam int INIT_LEVEL_DEF = 20;
  localparam int GAP_DEF        = 1;

  // Dispenser sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PULSE = 3'd1,
    ST_GAP   = 3'd2,
    ST_STALL = 3'd3,
    ST_DONE  = 3'd4
  } disp_state_t;

endpackage
`default_nettype wire

// File: rtl/coin_hopper.sv
`default_nettype none
// ============================================================================
// Module      : coin_hopper
// Description : Coin hopper level tracker. Decrements by one per dispensed
//               coin, adds refills, and saturates at the hopper capacity.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_hopper #(
  parameter int LVL_W      = 6,
  parameter int HOPPER_CAP = 50,
  parameter int INIT_LEVEL = 20
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             dec_i,
  input  logic             refill_i,
  input  logic [LVL_W-1:0] refill_amount_i,
  output logic [LVL_W-1:0] level_o,
  output logic [LVL_W-1:0] level_nxt_o,
  output logic             empty_o
);

  localparam logic [LVL_W:0] CAP_EXT = (LVL_W+1)'(HOPPER_CAP);

  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic [LVL_W:0]   sum_w;

  // One extra bit of headroom so level+refill never wraps before the clamp.
  // dec_i is only ever asserted with a non-zero level, so no underflow.
  always_comb begin
    sum_w   = {1'b0, level_q} - (LVL_W+1)'(dec_i)
            + (refill_i ? {1'b0, refill_amount_i} : '0);
    level_d = (sum_w > CAP_EXT) ? CAP_EXT[LVL_W-1:0] : sum_w[LVL_W-1:0];
  end

  // Level register, restored to the initial fill on reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_q <= LVL_W'(INIT_LEVEL);
    end else begin
      level_q <= level_d;
    end
  end

  assign level_o     = level_q;
  assign level_nxt_o = level_d;
  assign empty_o     = (level_q == '0);

endmodule
`default_nettype wire

// File: rtl/coin_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : coin_dispenser
// Description : Change-return transmitter. Accepts a refund request and
//               emits one-cycle coin pulses separated by GAP idle cycles,
//               stalling while the hopper is empty and resuming on refill.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_dispenser
  import coin_pkg::*;
#(
  parameter int AMT_W      = AMT_W_DEF,
  parameter int LVL_W      = LVL_W_DEF,
  parameter int HOPPER_CAP = HOPPER_CAP_DEF,
  parameter int INIT_LEVEL = INIT_LEVEL_DEF,
  parameter int GAP        = GAP_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             refill,
  input  logic [LVL_W-1:0] refill_amount,
  output logic             coin,
  output logic             done,
  output logic             busy,
  output logic             starved,
  output logic [LVL_W-1:0] level
);

  localparam int                GAP_CW   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_CW-1:0] GAP_LOAD = GAP_CW'(GAP - 1);

  disp_state_t       state_q, state_d;
  logic [AMT_W-1:0]  rem_q, rem_d;
  logic [GAP_CW-1:0] gap_q, gap_d;
  logic              coin_q, done_q, busy_q, starved_q;

  logic              empty_w;
  logic [LVL_W-1:0]  level_nxt_w;

  coin_hopper #(
    .LVL_W      (LVL_W),
    .HOPPER_CAP (HOPPER_CAP),
    .INIT_LEVEL (INIT_LEVEL)
  ) u_hopper (
    .clk             (clk),
    .rstn            (rstn),
    .dec_i           (state_q == ST_PULSE),
    .refill_i        (refill),
    .refill_amount_i (refill_amount),
    .level_o         (level),
    .level_nxt_o     (level_nxt_w),
    .empty_o         (empty_w)
  );

  // Next-state, remaining-count and gap-counter logic
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rem_d = req_amount;
          if (req_amount == '0)  state_d = ST_DONE;
          else if (empty_w)      state_d = ST_STALL;
          else                   state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        rem_d   = rem_q - AMT_W'(1);
        gap_d   = GAP_LOAD;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          if (rem_q == '0)  state_d = ST_DONE;
          else if (empty_w) state_d = ST_STALL;
          else              state_d = ST_PULSE;
        end else begin
          gap_d = gap_q - GAP_CW'(1);
        end
      end
      // Leave on the same edge the refill lands so the coin follows at once
      ST_STALL: begin
        if (level_nxt_w != '0) state_d = ST_PULSE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      gap_q     <= '0;
      coin_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      starved_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      coin_q    <= (state_d == ST_PULSE);
      done_q    <= (state_d == ST_DONE);
      busy_q    <= (state_d != ST_IDLE);
      starved_q <= (state_d == ST_STALL);
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign coin      = coin_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign starved   = starved_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_dispenser
// Description : Self-checking bench for coin_dispenser: request table,
//               stall/refill, saturation, mid-refund reset, back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_dispenser;

  localparam int AMT_W = 4;
  localparam int LVL_W = 6;
  localparam int CAP   = 50;
  localparam int INIT  = 20;
  localparam int GAP   = 1;
  localparam int PER   = 1 + GAP;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             req_ready;
  logic             refill = 1'b0;
  logic [LVL_W-1:0] refill_amount = '0;
  logic             coin, done, busy, starved;
  logic [LVL_W-1:0] level;

  coin_dispenser #(
    .AMT_W(AMT_W), .LVL_W(LVL_W), .HOPPER_CAP(CAP), .INIT_LEVEL(INIT), .GAP(GAP)
  ) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .refill(refill), .refill_amount(refill_amount),
    .coin(coin), .done(done), .busy(busy), .starved(starved), .level(level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int amount;
    int exp_level;
    int acc;
    bit timed;
  } sb_item_t;

  typedef struct {
    int amount;
    int exp_level;
  } vec_t;

  sb_item_t sb[$];
  sb_item_t mon_it;
  vec_t     vecs[5];

  int n_checks = 0;
  int n_pass = 0;
  int pulses_cur = 0;
  int total_coins = 0;
  int total_dones = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Scoreboard consumer: coins and done pulses against the pending request
  always @(negedge clk) begin
    if (!rstn) begin
      pulses_cur = 0;
      sb.delete();
    end else begin
      if (coin) begin
        total_coins++;
        chk("coin_pending", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          if (sb[0].timed) chk("coin_time", cyc - sb[0].acc, pulses_cur * PER);
          pulses_cur++;
        end
      end
      if (done) begin
        total_dones++;
        chk("done_pending", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mon_it = sb.pop_front();
          chk("done_pulses", pulses_cur, mon_it.amount);
          chk("done_level", int'(level), mon_it.exp_level);
          if (mon_it.timed) chk("done_time", cyc - mon_it.acc, mon_it.amount * PER);
          pulses_cur = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(int amt, int exp_lvl, bit timed);
    req_valid  = 1'b1;
    req_amount = AMT_W'(amt);
    tick();
    req_valid  = 1'b0;
    sb.push_back('{amount: amt, exp_level: exp_lvl, acc: cyc, timed: timed});
  endtask

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, int'(sb.size() != 0 || busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    int base_coins;
    int base_dones;

    vecs = '{'{3, 17}, '{0, 17}, '{5, 12}, '{1, 11}, '{9, 2}};

    // Reset values while rstn is held low
    repeat (2) tick();
    chk("rst_coin", int'(coin), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_starved", int'(starved), 0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_level", int'(level), INIT);
    rstn = 1'b1;
    tick();

    // Table of unstalled requests
    for (int i = 0; i < 5; i++) begin
      send_req(vecs[i].amount, vecs[i].exp_level, 1'b1);
      wait_idle("vec", 60);
      chk("vec_ready", int'(req_ready), 1);
      chk("vec_level", int'(level), vecs[i].exp_level);
    end

    // Starve: level 2, request 4, then refill 5
    send_req(4, 3, 1'b0);
    n = 0;
    while (!starved && n < 40) begin
      tick();
      n++;
    end
    chk("starve_enter", int'(starved), 1);
    chk("starve_level", int'(level), 0);
    chk("starve_pulses", pulses_cur, 2);
    repeat (4) tick();
    chk("starve_hold", int'(starved), 1);
    chk("starve_no_coin", pulses_cur, 2);
    refill = 1'b1;
    refill_amount = LVL_W'(5);
    tick();
    refill = 1'b0;
    chk("stall_exit_coin", int'(coin), 1);
    chk("stall_exit_starved", int'(starved), 0);
    wait_idle("starve", 60);
    chk("starve_final_level", int'(level), 3);

    // Saturation: level 49, refill 10 coincident with a pulse
    refill = 1'b1;
    refill_amount = LVL_W'(46);
    tick();
    refill = 1'b0;
    chk("refill_level", int'(level), 49);
    req_valid  = 1'b1;
    req_amount = AMT_W'(1);
    tick();
    req_valid = 1'b0;
    sb.push_back('{amount: 1, exp_level: CAP, acc: cyc, timed: 1'b1});
    refill = 1'b1;
    refill_amount = LVL_W'(10);
    tick();
    refill = 1'b0;
    chk("sat_level", int'(level), CAP);
    wait_idle("sat", 20);

    // Reset in the gap of a request of 5
    send_req(5, 0, 1'b1);
    tick();
    #2 rstn = 1'b0;
    #1;
    chk("rstgap_coin", int'(coin), 0);
    chk("rstgap_busy", int'(busy), 0);
    chk("rstgap_ready", int'(req_ready), 1);
    chk("rstgap_level", int'(level), INIT);
    tick();
    rstn = 1'b1;
    tick();

    // Reset during a coin pulse drops coin without a clock edge
    send_req(2, 0, 1'b1);
    chk("rstpulse_coin_hi", int'(coin), 1);
    #1 rstn = 1'b0;
    #1;
    chk("rstpulse_coin_lo", int'(coin), 0);
    chk("rstpulse_level", int'(level), INIT);
    tick();
    rstn = 1'b1;
    tick();

    // Clean restart after reset
    send_req(2, 18, 1'b1);
    wait_idle("restart", 30);

    // req_valid held high: amount 2 then 1, one acceptance per IDLE visit
    base_coins = total_coins;
    base_dones = total_dones;
    req_valid  = 1'b1;
    req_amount = AMT_W'(2);
    tick();
    k = cyc;
    req_amount = AMT_W'(1);
    sb.push_back('{amount: 2, exp_level: 16, acc: k, timed: 1'b1});
    sb.push_back('{amount: 1, exp_level: 15, acc: k + 2 * PER + 2, timed: 1'b1});
    repeat (2 * PER + 2) tick();
    req_valid = 1'b0;
    wait_idle("b2b", 40);
    repeat (3) tick();
    chk("b2b_coins", total_coins - base_coins, 3);
    chk("b2b_dones", total_dones - base_dones, 2);
    chk("b2b_idle", int'(busy), 0);
    chk("b2b_level", int'(level), 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
